debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised successor to the single-input switch debouncer: debounces N independent channels (fret buttons, strum bar, nav switches) in one block.
- Per-channel front end: built-in multi-flop synchroniser.
- Per-channel outputs: registered clean level, one-cycle rise/fall pulses, and an optional auto-repeat "press" pulse train for held buttons.
- Sits between board pins and game/menu logic, all in the system clock domain.

Parameters:
- N, 5: number of channels.
- DELAY, 1000000: cycles the synchronised input must differ stably from clean before clean flips (0.01 s @ 100 MHz); must be >= 1.
- NSYNC, 2: synchroniser flops per channel; must be >= 2.
- REPEAT_DELAY, 50000000: cycles after a rise before the first repeat pulse (0.5 s); must be >= 1.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses (0.1 s); must be >= 1.
- CLEAN_INIT, 0: reset value of every clean bit (0 or 1, applied to all channels).

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- noisy, input, N: raw asynchronous switch inputs.
- repeat_en, input, N: per-channel auto-repeat enable (synchronous to clock).
- clean, output, N: debounced level, registered.
- rise, output, N: one-cycle pulse when clean goes 0->1, registered.
- fall, output, N: one-cycle pulse when clean goes 1->0, registered.
- press, output, N: rise OR auto-repeat pulse, registered, one cycle wide.

Behaviour:
- Reset (async assert, sync-to-clock deassert by system):
  - all synchroniser flops = CLEAN_INIT;
  - clean = CLEAN_INIT;
  - counters = 0;
  - rise, fall and press = 0.
  - No pulses are generated as a result of reset itself.
- Synchroniser: s[i] is noisy[i] after NSYNC flops.
- Debounce counter cnt[i], width $clog2(DELAY+1), updated each edge:
  - if s == clean: cnt <= 0;
  - else if cnt == DELAY-1: clean <= s, cnt <= 0;
  - else: cnt <= cnt+1.
- Any return of s to clean before expiry clears the counter (glitch rejection).
- Latency:
  - a step on noisy, first sampled at edge 1 and held stable, changes clean at edge NSYNC+DELAY;
  - rise/fall assert at that same edge for exactly one cycle.
- Repeat counter rc[i], width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - Cleared to 0 on rise and whenever clean == 0 or repeat_en == 0.
  - While clean == 1 and repeat_en == 1, increments each cycle.
  - On reaching REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (subsequent repeats): emits a repeat pulse and reloads to 0.
  - A per-channel "first_done" flag selects the threshold; it is cleared together with rc.
- press = rise | repeat pulse, registered in the same edge as the event.
  - With repeat_en held high, a held press generates pulses at edges:
    - T (the rise edge),
    - T+REPEAT_DELAY,
    - T+REPEAT_DELAY+REPEAT_PERIOD, and so on.
- Dropping repeat_en mid-hold:
  - stops pulses next edge and clears rc;
  - re-raising it restarts with REPEAT_DELAY (first_done cleared).
- Simultaneous events:
  - rise and the repeat pulse can never coincide, because rc is cleared on rise;
  - fall suppresses any repeat pulse in the same cycle.
- Channels are fully independent; any number may flip on the same edge.
- Reset mid-count: all state returns to its reset values immediately, and no pulse is emitted on reset release.

Decomposition:
- Shared include header (utils constants): a clog2-style width helper, and default timing constants for 100 MHz: DEBOUNCE_10MS, REPEAT_500MS, REPEAT_100MS.
- One sub-module, debounce_channel, containing:
  - the synchroniser, the debounce counter and the clean, rise, fall and press registers;
  - parameters NSYNC, DELAY, REPEAT_DELAY, REPEAT_PERIOD and CLEAN_INIT.
- debounce_bank is a generate loop of N debounce_channel instances.

Test Plan (bench parameters N=2, DELAY=4, NSYNC=2, REPEAT_DELAY=10, REPEAT_PERIOD=3, CLEAN_INIT=0):
1. Reset, then noisy=0 for 20 cycles -> clean=0; rise, fall and press never assert.
2. noisy[0] 0->1 sampled at edge 1 and held -> clean[0]=1 at edge 6; rise[0] and press[0] high only in the cycle after edge 6; channel 1 untouched.
3. noisy[0] high for 3 cycles then low (glitch shorter than DELAY) -> clean[0] stays 0; cnt returns to 0; no pulses.
4. repeat_en[1]=1 and noisy[1] held high, rise at edge T -> press[1] pulses at T, T+10, T+13, T+16; release noisy[1] -> fall[1] at release_edge+6 and no further press.
5. Hold noisy[1] high, drop repeat_en[1] at T+12 and re-raise it at T+20 -> no pulse at T+13; next pulses at T+30, T+33.
6. Assert reset asynchronously mid-count (cnt=2) and mid-hold (clean=1) -> clean, rise, fall and press read 0 immediately (before the next edge); no pulse after release until a fresh stable change of 6 cycles.

Source files
------------

// File: rtl/debounce_bank_pkg.sv
// Shared constants and width helpers for the debounce bank.
// Timing defaults assume a 100 MHz system clock.
package debounce_bank_pkg;

  localparam int unsigned DEBOUNCE_10MS = 1_000_000;
  localparam int unsigned REPEAT_500MS  = 50_000_000;
  localparam int unsigned REPEAT_100MS  = 10_000_000;

  // Bits needed to hold any value in 0..max_val (same as $clog2(max_val+1), minimum 1).
  function automatic int unsigned width_for(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_val)) w++;
    return w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch: synchroniser, stability counter, edge pulses and
// auto-repeat press train for a held button.
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int unsigned NSYNC         = 2,
  parameter int unsigned DELAY         = DEBOUNCE_10MS,
  parameter int unsigned REPEAT_DELAY  = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD = REPEAT_100MS,
  parameter bit          CLEAN_INIT    = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy,
  input  logic repeat_en,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int unsigned CW = width_for(DELAY);
  localparam int unsigned RW = width_for(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [CW-1:0] CNT_LAST   = CW'(DELAY - 1);
  localparam logic [RW-1:0] FIRST_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

  logic [NSYNC-1:0] r_sync;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_rc;
  logic             r_first_done;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;
  logic             r_press;

  logic w_s;
  logic w_expire;
  logic w_rise;
  logic w_fall;
  logic w_rep_hold;
  logic w_rep;

  // NOTE: every signal is assigned unconditionally here, so no latch is inferred.
  always_comb begin
    w_s        = r_sync[NSYNC-1];
    w_expire   = (w_s != r_clean) && (r_cnt == CNT_LAST);
    w_rise     = w_expire && w_s;
    w_fall     = w_expire && !w_s;
    // A flip this edge (fall, since rise needs clean==0) kills any repeat pulse.
    w_rep_hold = r_clean && repeat_en && !w_expire;
    w_rep      = w_rep_hold && (r_rc == (r_first_done ? NEXT_LAST : FIRST_LAST));
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync       <= {NSYNC{CLEAN_INIT}};
      r_cnt        <= '0;
      r_rc         <= '0;
      r_first_done <= 1'b0;
      r_clean      <= CLEAN_INIT;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_press      <= 1'b0;
    end else begin
      r_sync <= {r_sync[NSYNC-2:0], noisy};

      if (w_s == r_clean) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_clean <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (!w_rep_hold) begin
        r_rc         <= '0;
        r_first_done <= 1'b0;
      end else if (w_rep) begin
        r_rc         <= '0;
        r_first_done <= 1'b1;
      end else begin
        r_rc <= r_rc + 1'b1;
      end

      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_press <= w_rise | w_rep;
    end
  end

  assign clean = r_clean;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign press = r_press;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent debounced switch channels sharing one clock and reset.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int unsigned N             = 5,
  parameter int unsigned DELAY         = DEBOUNCE_10MS,
  parameter int unsigned NSYNC         = 2,
  parameter int unsigned REPEAT_DELAY  = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD = REPEAT_100MS,
  parameter bit          CLEAN_INIT    = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] noisy,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] press
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .NSYNC        (NSYNC),
      .DELAY        (DELAY),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CLEAN_INIT   (CLEAN_INIT)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .noisy    (noisy[i]),
      .repeat_en(repeat_en[i]),
      .clean    (clean[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .press    (press[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus randomized
// switch activity against a timestamp-based reference model.
module tb_debounce_bank;

  localparam int N     = 2;
  localparam int DELAY = 4;
  localparam int NSYNC = 2;
  localparam int RD    = 10;
  localparam int RP    = 3;
  localparam bit CI    = 1'b0;
  localparam int LAT   = NSYNC + DELAY;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] noisy = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] clean, rise, fall, press;

  int cmp_n = 0;
  int err_n = 0;

  debounce_bank #(
    .N(N), .DELAY(DELAY), .NSYNC(NSYNC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CLEAN_INIT(CI)
  ) dut (
    .clock(clock), .reset(reset), .noisy(noisy), .repeat_en(repeat_en),
    .clean(clean), .rise(rise), .fall(fall), .press(press)
  );

  always #5 clock = ~clock;

  // Reference model: pins reach the logic NSYNC edges late; clean flips after
  // DELAY consecutive differing samples; repeats are scheduled by timestamps.
  bit [N-1:0] m_clean, m_rise, m_fall, m_press;
  bit         pin_q [N][$];
  bit         win   [N][$];
  int         anchor [N];
  int         gap    [N];
  int         edge_n;

  task automatic model_reset();
    edge_n  = 0;
    m_clean = {N{CI}};
    m_rise  = '0;
    m_fall  = '0;
    m_press = '0;
    for (int ch = 0; ch < N; ch++) begin
      pin_q[ch].delete();
      for (int k = 0; k < NSYNC; k++) pin_q[ch].push_back(CI);
      win[ch].delete();
      anchor[ch] = 0;
      gap[ch]    = RD;
    end
  endtask

  task automatic model_update();
    bit s, old, flip, rep;
    edge_n++;
    for (int ch = 0; ch < N; ch++) begin
      s = pin_q[ch].pop_front();
      pin_q[ch].push_back(noisy[ch]);
      old = m_clean[ch];
      if (s == old) win[ch].delete();
      else          win[ch].push_back(s);
      flip = (win[ch].size() == DELAY);
      if (flip) win[ch].delete();
      rep = 1'b0;
      if (flip || !old || !repeat_en[ch]) begin
        anchor[ch] = edge_n;
        gap[ch]    = RD;
      end else if (edge_n - anchor[ch] == gap[ch]) begin
        rep        = 1'b1;
        anchor[ch] = edge_n;
        gap[ch]    = RP;
      end
      m_rise[ch]  = flip && s;
      m_fall[ch]  = flip && !s;
      m_clean[ch] = flip ? s : old;
      m_press[ch] = m_rise[ch] | rep;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_update();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    noisy = '0;
    repeat_en = '0;
    repeat (3) @(negedge clock);
    cmp_n++;
    if ({clean, rise, fall, press} !== '0) begin
      err_n++;
      $display("FAIL reset_state: got %b want 0", {clean, rise, fall, press});
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      cmp_n++;
      if ({clean, rise, fall, press} !== '0) begin
        err_n++;
        $display("FAIL idle edge %0d: got %b want 0", edge_n, {clean, rise, fall, press});
      end
    end
  endtask

  task automatic test_rise_fall();
    int  e0;
    logic [3:0] exp0;
    e0 = edge_n;
    noisy[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (edge_n == e0 + 10) noisy[0] = 1'b0;
      tick();
      // ch0 goes high at e0+LAT and back low at e0+10+LAT
      exp0 = {(edge_n >= e0 + LAT) && (edge_n < e0 + 10 + LAT),
              edge_n == e0 + LAT, edge_n == e0 + 10 + LAT, edge_n == e0 + LAT};
      cmp_n++;
      if ({clean[0], rise[0], fall[0], press[0]} !== exp0 ||
          {clean[1], rise[1], fall[1], press[1]} !== 4'b0) begin
        err_n++;
        $display("FAIL step_latency edge %0d: ch0 got %b want %b, ch1 got %b want 0000", edge_n,
                 {clean[0], rise[0], fall[0], press[0]}, exp0,
                 {clean[1], rise[1], fall[1], press[1]});
      end
      cmp_n++;
      if ({clean, rise, fall, press} !== {m_clean, m_rise, m_fall, m_press}) begin
        err_n++;
        $display("FAIL step_model edge %0d: got %b want %b", edge_n,
                 {clean, rise, fall, press}, {m_clean, m_rise, m_fall, m_press});
      end
    end
  endtask

  task automatic test_glitch();
    // 3 high, 1 low, 3 high: a counter that failed to clear would flip clean.
    bit pat [$];
    pat = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int r = 0; r < 3; r++) begin
      if (r > 0) begin
        pat.delete();
        for (int g = 0; g < 3; g++) begin
          repeat ($urandom_range(1, DELAY - 1)) pat.push_back(1'b1);
          repeat ($urandom_range(1, 2)) pat.push_back(1'b0);
        end
        repeat (8) pat.push_back(1'b0);
      end
      foreach (pat[k]) begin
        noisy[0] = pat[k];
        tick();
        cmp_n++;
        if ({clean[0], rise[0], fall[0], press[0]} !== 4'b0) begin
          err_n++;
          $display("FAIL glitch edge %0d: ch0 got %b want 0000", edge_n,
                   {clean[0], rise[0], fall[0], press[0]});
        end
      end
    end
  endtask

  task automatic test_repeat();
    int  t, k;
    bit  exp_p, exp_c, exp_f;
    repeat_en[1] = 1'b1;
    noisy[1] = 1'b1;
    t = edge_n + LAT;
    while (edge_n < t + 32) begin
      if (edge_n == t + 17) noisy[1] = 1'b0;
      tick();
      k = edge_n - t;
      exp_c = (k >= 0) && (k < 17 + LAT);
      exp_f = (k == 17 + LAT);
      exp_p = (k == 0) || (k >= RD && (k - RD) % RP == 0 && k < 17 + LAT);
      cmp_n++;
      if ({clean[1], fall[1], press[1]} !== {exp_c, exp_f, exp_p}) begin
        err_n++;
        $display("FAIL repeat_train k=%0d: ch1 clean/fall/press got %b want %b", k,
                 {clean[1], fall[1], press[1]}, {exp_c, exp_f, exp_p});
      end
      cmp_n++;
      if ({clean, rise, fall, press} !== {m_clean, m_rise, m_fall, m_press}) begin
        err_n++;
        $display("FAIL repeat_model edge %0d: got %b want %b", edge_n,
                 {clean, rise, fall, press}, {m_clean, m_rise, m_fall, m_press});
      end
    end
  endtask

  task automatic test_repeat_gate();
    int  t, k;
    bit  exp_p;
    repeat_en[1] = 1'b1;
    noisy[1] = 1'b1;
    t = edge_n + LAT;
    while (edge_n < t + 37) begin
      if (edge_n == t + 12) repeat_en[1] = 1'b0;
      if (edge_n == t + 20) repeat_en[1] = 1'b1;
      tick();
      k = edge_n - t;
      exp_p = (k == 0) || (k == 10) || (k == 30) || (k == 33) || (k == 36);
      cmp_n++;
      if (press[1] !== exp_p) begin
        err_n++;
        $display("FAIL repeat_gate k=%0d: press[1] got %b want %b", k, press[1], exp_p);
      end
      cmp_n++;
      if ({clean, rise, fall, press} !== {m_clean, m_rise, m_fall, m_press}) begin
        err_n++;
        $display("FAIL gate_model edge %0d: got %b want %b", edge_n,
                 {clean, rise, fall, press}, {m_clean, m_rise, m_fall, m_press});
      end
    end
    noisy[1] = 1'b0;
    repeat (10) tick();
    repeat_en[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp_r;
    noisy[1] = 1'b1;
    repeat_en[1] = 1'b1;
    repeat (LAT + 2) tick();
    noisy[0] = 1'b1;
    repeat (NSYNC + 2) tick();
    cmp_n++;
    if (clean !== 2'b10) begin
      err_n++;
      $display("FAIL pre_reset_clean: got %b want 10", clean);
    end
    #2 reset = 1'b1;
    #1;
    cmp_n++;
    if ({clean, rise, fall, press} !== '0) begin
      err_n++;
      $display("FAIL async_reset: got %b want 0", {clean, rise, fall, press});
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_r = (edge_n == LAT) ? 2'b11 : 2'b00;
      cmp_n++;
      if (rise !== exp_r || press !== exp_r || fall !== 2'b00) begin
        err_n++;
        $display("FAIL post_reset edge %0d: rise %b press %b fall %b want rise/press %b fall 00",
                 edge_n, rise, press, fall, exp_r);
      end
      cmp_n++;
      if ({clean, rise, fall, press} !== {m_clean, m_rise, m_fall, m_press}) begin
        err_n++;
        $display("FAIL post_reset_model edge %0d: got %b want %b", edge_n,
                 {clean, rise, fall, press}, {m_clean, m_rise, m_fall, m_press});
      end
    end
  endtask

  task automatic test_random();
    int hold [N];
    for (int ch = 0; ch < N; ch++) hold[ch] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          noisy[ch] = 1'($urandom_range(0, 1));
          hold[ch]  = (($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 7));
        end
        hold[ch]--;
        if ($urandom_range(0, 49) == 0) repeat_en[ch] = ~repeat_en[ch];
      end
      tick();
      cmp_n++;
      if ({clean, rise, fall, press} !== {m_clean, m_rise, m_fall, m_press}) begin
        err_n++;
        $display("FAIL random_model edge %0d: got %b want %b", edge_n,
                 {clean, rise, fall, press}, {m_clean, m_rise, m_fall, m_press});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rise_fall();
    test_glitch();
    test_repeat();
    test_repeat_gate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
